first_counter: RTL and testbench

FIRST_COUNTER -- requirements
Module: first_counter

---
 rtl/first_counter.sv | 58 +++++
 tb/tb_first_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/first_counter.sv
// first_counter: WIDTH-bit up counter with enable and a sticky overflow flag.
// Synchronous active-high reset clears both the count and the flag.
// Build option: define FIRST_COUNTER_SATURATE_EN to make the counter stop at
// its maximum value instead of wrapping to zero. The overflow flag is set
// the same way in both builds. The default build (macro undefined) wraps.
// Only WIDTH=4 is a supported build.
module first_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   output logic [WIDTH-1:0] counter_out,
   output logic             overflow_out
);

   logic [WIDTH-1:0] count_reg;
   logic [WIDTH-1:0] count_next;
   logic             overflow_reg;
   logic             overflow_next;
   logic             at_max;

   // The count is at its maximum value when every bit is set.
   assign at_max = &count_reg;

   // Next-state: increment when enabled; at the maximum either wrap or saturate, and latch overflow.
   always_comb begin
      count_next    = count_reg;
      overflow_next = overflow_reg;
      if (enable) begin
         if (at_max) begin
`ifdef FIRST_COUNTER_SATURATE_EN
            count_next = count_reg;
`else
            count_next = '0;
`endif
            overflow_next = 1'b1;
         end else begin
            count_next = count_reg + WIDTH'(1);
         end
      end
   end

   // State registers; reset wins over enable and only acts on the clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
      end
   end

   assign counter_out  = count_reg;
   assign overflow_out = overflow_reg;

endmodule

// File: tb/tb_first_counter.sv
// Self-checking bench for first_counter: a table of fixed vectors, hand-written
// multi-cycle sequences, and randomized stimulus checked against a model.
module tb_first_counter;

`ifdef FIRST_COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] counter_out;
   logic       overflow_out;

   int total;
   int bad;

   // Reference model state: count as a plain integer, sticky flag as a bit.
   int m_count;
   bit m_ovf;

   typedef struct {
      bit       r;
      bit       e;
      int       exp_count;
      bit       exp_ovf;
   } vec_t;

   vec_t vecs [0:13];

   first_counter #(.WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .counter_out  (counter_out),
      .overflow_out (overflow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model of the counting rules: reset clears, an enabled edge adds one;
   // reaching past the top either wraps (mod 16) or clamps at 15, and sets the flag.
   task automatic model_step(input bit r, input bit e);
      if (r) begin
         m_count = 0;
         m_ovf   = 1'b0;
      end else if (e) begin
         if (m_count + 1 > 15) m_ovf = 1'b1;
         if (SAT) m_count = (m_count + 1 > 15) ? 15 : m_count + 1;
         else     m_count = (m_count + 1) % 16;
      end
   endtask

   // Drive inputs, take one rising edge, sample 1 time unit later.
   task automatic tick(input bit r, input bit e);
      reset  = r;
      enable = e;
      @(posedge clk);
      #1;
      model_step(r, e);
   endtask

   task automatic run(input bit r, input bit e, input int n);
      for (int i = 0; i < n; i++) tick(r, e);
   endtask

   task automatic chk(input string name, input int exp_c, input bit exp_o);
      total++;
      if (counter_out !== 4'(exp_c) || overflow_out !== exp_o) begin
         bad++;
         $display("FAIL %s: got count=%0d ovf=%b, want count=%0d ovf=%b",
                  name, counter_out, overflow_out, exp_c, exp_o);
      end else begin
         $display("ok   %s: count=%0d ovf=%b", name, counter_out, overflow_out);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      total  = 0;
      bad    = 0;
      m_count = 0;
      m_ovf   = 1'b0;
      reset  = 1'b0;
      enable = 1'b0;

      // Vector table: {reset, enable, expected count, expected overflow}.
      vecs[0]  = '{1'b1, 1'b0, 0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 2, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 2, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 3, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 2, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 3, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 3, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 0, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 14; i++) begin
         tick(vecs[i].r, vecs[i].e);
         chk($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_ovf);
      end

      // Reset only, then hold for 5 edges.
      tick(1'b1, 1'b0);
      chk("reset_only", 0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("reset_hold%0d", i), 0, 1'b0);
      end

      // Count 10.
      tick(1'b1, 1'b0);
      run(1'b0, 1'b1, 10);
      chk("count10", 10, 1'b0);

      // Edge at 15 with enable low must not set overflow.
      run(1'b0, 1'b1, 5);
      chk("at15", 15, 1'b0);
      run(1'b0, 1'b0, 2);
      chk("hold_at15_no_ovf", 15, 1'b0);

      // Wrap at 16 edges, continue to 20.
      tick(1'b1, 1'b0);
      run(1'b0, 1'b1, 16);
      chk("wrap16", SAT ? 15 : 0, 1'b1);
      run(1'b0, 1'b1, 4);
      chk("wrap20", SAT ? 15 : 4, 1'b1);
      run(1'b0, 1'b0, 3);
      chk("sticky_hold", SAT ? 15 : 4, 1'b1);

      // Hold: count to 7, hold 3, one more.
      tick(1'b1, 1'b0);
      run(1'b0, 1'b1, 7);
      chk("to7", 7, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b0);
         chk($sformatf("hold7_%0d", i), 7, 1'b0);
      end
      tick(1'b0, 1'b1);
      chk("after_hold8", 8, 1'b0);

      // Reset pulse between edges has no effect.
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick(1'b0, 1'b1);
      chk("glitch_reset_ignored", 9, 1'b0);

      // Reset mid-run after overflow, with enable high.
      run(1'b0, 1'b1, 10);
      chk("past_wrap", SAT ? 15 : 3, 1'b1);
      tick(1'b1, 1'b1);
      chk("reset_prio", 0, 1'b0);
      tick(1'b0, 1'b1);
      chk("resume1", 1, 1'b0);

      // Long run of 100 edges, flag expected from edge 16 onward.
      tick(1'b1, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         tick(1'b0, 1'b1);
         chk($sformatf("long%0d", i),
             SAT ? ((i > 15) ? 15 : i) : (i % 16), (i >= 16));
      end
      chk("long_final", SAT ? 15 : 4, 1'b1);

      // Randomized stimulus against the model.
      tick(1'b1, 1'b0);
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 24) == 0), $urandom_range(0, 3) != 0);
         chk($sformatf("rand%0d", i), m_count, m_ovf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
